// File: rtl/i2c_txn_sequencer.sv
// Drives the byte-level I2C core through START, address, N data bytes and STOP for one command at a time.
// First core pulse 1 cycle after accept; wr stream stalls on wr_ready, cmd_valid while busy is dropped.
module i2c_txn_sequencer #(
    parameter int LEN_W   = 4,
    parameter int TMO_W   = 16,
    parameter int TMO_MAX = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rnw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             txn_done,
    output logic             err_nack,
    output logic             err_tmo,
    input  logic             core_ready,
    input  logic             core_done,
    input  logic             core_ack,
    input  logic [7:0]       core_rdata,
    output logic             core_start,
    output logic             core_stop,
    output logic             core_write,
    output logic             core_read,
    output logic             core_nack,
    output logic [7:0]       core_wdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_WFETCH, S_WR, S_RD, S_STOP, S_FIN
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_ZERO = '0;

    state_t           state, state_nxt;
    logic             issued, issued_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [6:0]       addr_q, addr_nxt;
    logic             rnw_q, rnw_nxt;
    logic             nack_nxt, tmo_err_nxt, rd_valid_nxt;
    logic [7:0]       wdata_nxt, rd_data_nxt;
    logic             is_issue, pulse, done_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            issued     <= 1'b0;
            tmo_cnt    <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            err_nack   <= 1'b0;
            err_tmo    <= 1'b0;
            core_wdata <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            issued     <= issued_nxt;
            tmo_cnt    <= tmo_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= addr_nxt;
            rnw_q      <= rnw_nxt;
            err_nack   <= nack_nxt;
            err_tmo    <= tmo_err_nxt;
            core_wdata <= wdata_nxt;
            rd_data    <= rd_data_nxt;
            rd_valid   <= rd_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        issued_nxt   = issued;
        tmo_nxt      = tmo_cnt;
        cnt_nxt      = cnt;
        addr_nxt     = addr_q;
        rnw_nxt      = rnw_q;
        nack_nxt     = err_nack;
        tmo_err_nxt  = err_tmo;
        wdata_nxt    = core_wdata;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = 1'b0;
        core_start   = 1'b0;
        core_stop    = 1'b0;
        core_write   = 1'b0;
        core_read    = 1'b0;
        pulse        = 1'b0;
        done_ok      = 1'b0;

        is_issue = (state == S_START) || (state == S_ADDR) || (state == S_WR) ||
                   (state == S_RD)    || (state == S_STOP);

        // One pulse per issuing state, then wait for done; done beats the watchdog in the same cycle.
        if (is_issue) begin
            if (!issued) begin
                if (core_ready) begin
                    pulse      = 1'b1;
                    issued_nxt = 1'b1;
                    tmo_nxt    = '0;
                end
            end else if (core_done) begin
                issued_nxt = 1'b0;
                done_ok    = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
                issued_nxt  = 1'b0;
                tmo_err_nxt = 1'b1;
                state_nxt   = S_FIN;
            end else begin
                tmo_nxt = tmo_cnt + TMO_ONE;
            end
        end

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_nxt    = cmd_addr;
                    rnw_nxt     = cmd_rnw;
                    cnt_nxt     = cmd_len;
                    nack_nxt    = 1'b0;
                    tmo_err_nxt = 1'b0;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                core_start = pulse;
                if (done_ok) begin
                    wdata_nxt = {addr_q, rnw_q};
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                core_write = pulse;
                if (done_ok) begin
                    if (!core_ack) begin
                        nack_nxt  = 1'b1;
                        state_nxt = S_STOP;
                    end else if (cnt == CNT_ZERO) begin
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt = rnw_q ? S_RD : S_WFETCH;
                    end
                end
            end
            S_WFETCH: begin
                if (wr_valid) begin
                    wdata_nxt = wr_data;
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                core_write = pulse;
                if (done_ok) begin
                    if (cnt != CNT_ZERO) cnt_nxt = cnt - CNT_ONE;
                    if (!core_ack) begin
                        nack_nxt  = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt = (cnt <= CNT_ONE) ? S_STOP : S_WFETCH;
                    end
                end
            end
            S_RD: begin
                core_read = pulse;
                if (done_ok) begin
                    rd_data_nxt  = core_rdata;
                    rd_valid_nxt = 1'b1;
                    if (cnt != CNT_ZERO) cnt_nxt = cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                core_stop = pulse;
                if (done_ok) state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_WFETCH);
    assign txn_done  = (state == S_FIN);
    assign busy      = (state != S_IDLE) && (state != S_FIN);
    assign core_nack = (state == S_RD) && (cnt == CNT_ONE);

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Random transactions against a transaction-level expectation of the core command stream.
module tb_i2c_txn_sequencer;

    localparam int TMO_MAX = 20;

    logic       clk, reset;
    logic       cmd_valid, cmd_ready, cmd_rnw;
    logic [6:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data, rd_data, core_rdata, core_wdata;
    logic       wr_valid, wr_ready, rd_valid, busy, txn_done, err_nack, err_tmo;
    logic       core_ready, core_done, core_ack;
    logic       core_start, core_stop, core_write, core_read, core_nack;

    i2c_txn_sequencer #(.LEN_W(4), .TMO_W(16), .TMO_MAX(TMO_MAX)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rnw(cmd_rnw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .txn_done(txn_done), .err_nack(err_nack), .err_tmo(err_tmo),
        .core_ready(core_ready), .core_done(core_done), .core_ack(core_ack),
        .core_rdata(core_rdata),
        .core_start(core_start), .core_stop(core_stop), .core_write(core_write),
        .core_read(core_read), .core_nack(core_nack), .core_wdata(core_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ev(input logic [3:0] t, input logic n, input logic [7:0] d);
        return {t, 3'b000, n, d};
    endfunction

    function automatic logic [27:0] out_vec();
        return {busy, cmd_ready, txn_done, err_nack, err_tmo, wr_ready, rd_valid,
                core_start, core_stop, core_write, core_read, core_nack, rd_data, core_wdata};
    endfunction

    // Per-transaction configuration, indexed by core command number within the transaction
    bit         ack_by_ev[32];
    logic [7:0] rd_by_ev[32];
    logic [7:0] wr_bytes[16];
    int         hang_at;
    bit         rdy_always;
    logic [7:0] wr_q[$];

    // Observations
    logic [15:0] obs_ev[$];
    logic [7:0]  obs_rd[$];
    int obs_wr, obs_acc, obs_done, viol, cyc;
    int acc_cyc, start_cyc, pulse_cyc, done_cyc;
    logic obs_nack, obs_tmo;

    // Expectations
    logic [15:0] exp_ev[$];
    logic [7:0]  exp_rd[$];
    int exp_wr;
    bit exp_nack, exp_tmo;

    // Core model + write-stream source + monitor: sample at negedge, drive just after posedge
    initial begin
        bit c_busy, c_hang, c_is_wr;
        int c_delay, c_ev, c_cur;
        logic [7:0] c_wdata;
        logic [3:0] p;
        logic n_done, n_ready, n_ack, n_wvalid;
        logic [7:0] n_rdata, n_wdata;
        c_busy = 0; c_hang = 0; c_is_wr = 0; c_delay = 0; c_ev = 0; c_cur = 0; c_wdata = 0;
        forever begin
            @(negedge clk);
            cyc++;
            n_done = 1'b0; n_ready = core_ready; n_ack = core_ack; n_rdata = core_rdata;
            n_wvalid = wr_valid; n_wdata = wr_data;
            if (reset) begin
                c_busy = 0; c_ev = 0; n_ready = 1'b0; n_wvalid = 1'b0;
            end else begin
                p = {core_start, core_write, core_read, core_stop};
                if (p != 4'b0000) begin
                    if (c_busy || !core_ready || $countones(p) != 1) viol++;
                    if (core_start) begin obs_ev.push_back(ev(4'd1, core_nack, 8'h00)); start_cyc = cyc; end
                    if (core_write) obs_ev.push_back(ev(4'd2, core_nack, core_wdata));
                    if (core_read)  obs_ev.push_back(ev(4'd3, core_nack, 8'h00));
                    if (core_stop)  obs_ev.push_back(ev(4'd4, core_nack, 8'h00));
                    pulse_cyc = cyc;
                    c_busy = 1; c_delay = $urandom_range(0, 3); c_hang = (c_ev == hang_at);
                    c_is_wr = core_write; c_wdata = core_wdata; c_cur = c_ev; c_ev++;
                    n_ready = 1'b0;
                end else if (c_busy && !c_hang) begin
                    if (c_is_wr && core_wdata != c_wdata) viol++;
                    if (c_delay == 0) begin
                        n_done = 1'b1; n_ack = ack_by_ev[c_cur]; n_rdata = rd_by_ev[c_cur];
                        c_busy = 0;
                    end else begin
                        c_delay--;
                    end
                end else if (!c_busy) begin
                    n_ready = rdy_always || ($urandom_range(0, 3) != 0);
                end
                if (wr_valid && wr_ready) begin
                    obs_wr++;
                    void'(wr_q.pop_front());
                    n_wvalid = 1'b0;
                end
                if (!n_wvalid && wr_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    n_wvalid = 1'b1; n_wdata = wr_q[0];
                end
                if (rd_valid) obs_rd.push_back(rd_data);
                if (cmd_valid && cmd_ready) begin obs_acc++; acc_cyc = cyc; end
                if (txn_done) begin
                    obs_done = 1; done_cyc = cyc; obs_nack = err_nack; obs_tmo = err_tmo;
                    c_busy = 0; c_ev = 0; wr_q.delete(); n_wvalid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            core_done = n_done; core_ready = n_ready; core_ack = n_ack; core_rdata = n_rdata;
            wr_valid = n_wvalid; wr_data = n_wdata;
        end
    end

    // Expected command stream from the transaction rules, then cut at the hung command
    task automatic build_model(input logic [6:0] a, input bit rnw, input int len);
        logic [15:0] full[$];
        int kind[$];
        bit nk[$];
        int k;
        exp_ev.delete(); exp_rd.delete(); exp_wr = 0; exp_nack = 0; exp_tmo = 0;
        full.push_back(ev(4'd1, 1'b0, 8'h00)); kind.push_back(0); nk.push_back(0);
        full.push_back(ev(4'd2, 1'b0, {a, rnw})); kind.push_back(0); nk.push_back(!ack_by_ev[1]);
        if (ack_by_ev[1] && len > 0) begin
            for (int i = 0; i < len; i++) begin
                k = full.size();
                if (rnw) begin
                    full.push_back(ev(4'd3, (i == len - 1), 8'h00)); kind.push_back(2); nk.push_back(0);
                end else begin
                    full.push_back(ev(4'd2, 1'b0, wr_bytes[i])); kind.push_back(1);
                    nk.push_back(!ack_by_ev[k]);
                    if (!ack_by_ev[k]) break;
                end
            end
        end
        full.push_back(ev(4'd4, 1'b0, 8'h00)); kind.push_back(0); nk.push_back(0);
        for (int i = 0; i < full.size(); i++) begin
            exp_ev.push_back(full[i]);
            if (kind[i] == 1) exp_wr++;
            if (i == hang_at) begin exp_tmo = 1; break; end
            if (kind[i] == 2) exp_rd.push_back(rd_by_ev[i]);
            if (nk[i]) exp_nack = 1;
        end
    endtask

    task automatic rand_cfg(input bit all_ack);
        for (int i = 0; i < 32; i++) begin
            ack_by_ev[i] = all_ack || ($urandom_range(0, 9) != 0);
            rd_by_ev[i]  = 8'($urandom);
        end
        for (int i = 0; i < 16; i++) wr_bytes[i] = 8'($urandom);
    endtask

    task automatic run_txn(input logic [6:0] a, input bit rnw, input int len, input int hang,
                           input bit rdy_all, input bit abort, input string nm);
        int n;
        @(posedge clk);
        #1;
        obs_ev.delete(); obs_rd.delete(); obs_wr = 0; obs_acc = 0; obs_done = 0;
        hang_at = hang; rdy_always = rdy_all;
        wr_q.delete();
        if (!rnw) for (int i = 0; i < len; i++) wr_q.push_back(wr_bytes[i]);
        build_model(a, rnw, len);
        cmd_addr = a; cmd_rnw = rnw; cmd_len = 4'(len); cmd_valid = 1'b1;
        n = 0;
        while (obs_acc == 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        if (obs_acc == 0) check_val({nm, "_accept_timeout"}, 0, 1);
        if (!abort) begin
            cmd_addr = ~a;
            repeat (2) @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (abort) begin
            n = 0;
            while (obs_rd.size() == 0 && n < 1000) begin @(posedge clk); n++; end
            check_val({nm, "_rd1_seen"}, obs_rd.size(), 1);
            #1;
            reset = 1'b1;
            @(negedge clk);
            check_val({nm, "_reset_outputs"}, {4'h0, out_vec()}, {4'h0, 1'b0, 1'b1, 26'd0});
            @(posedge clk);
            #1;
            reset = 1'b0;
            return;
        end
        n = 0;
        while (obs_done == 0 && n < 3000) begin @(posedge clk); n++; end
        if (obs_done == 0) check_val({nm, "_done_timeout"}, 0, 1);
        check_val({nm, "_ev_cnt"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++)
            check_val($sformatf("%s_ev%0d", nm, i), {16'h0, obs_ev[i]}, {16'h0, exp_ev[i]});
        check_val({nm, "_rd_cnt"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
            check_val($sformatf("%s_rd%0d", nm, i), {24'h0, obs_rd[i]}, {24'h0, exp_rd[i]});
        check_val({nm, "_wr_consumed"}, obs_wr, exp_wr);
        check_val({nm, "_err_nack"}, {31'h0, obs_nack}, {31'h0, exp_nack});
        check_val({nm, "_err_tmo"}, {31'h0, obs_tmo}, {31'h0, exp_tmo});
        check_val({nm, "_accepts"}, obs_acc, 1);
        if (exp_tmo) check_val({nm, "_tmo_latency"}, done_cyc - pulse_cyc, TMO_MAX + 1);
        if (rdy_all) check_val({nm, "_start_latency"}, start_cyc - acc_cyc, 1);
    endtask

    initial begin
        logic [6:0] a;
        bit rnw;
        int len, hang;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rnw = 1'b0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; core_ready = 1'b0; core_done = 1'b0; core_ack = 1'b0;
        core_rdata = '0; hang_at = -1; rdy_always = 0; viol = 0; cyc = 0;
        obs_wr = 0; obs_acc = 0; obs_done = 0; obs_nack = 0; obs_tmo = 0;
        acc_cyc = 0; start_cyc = 0; pulse_cyc = 0; done_cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_state", {4'h0, out_vec()}, {4'h0, 1'b0, 1'b1, 26'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        rand_cfg(1);
        wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C;
        run_txn(7'h50, 1'b0, 2, -1, 1'b1, 1'b0, "wr2");

        rand_cfg(1);
        rd_by_ev[2] = 8'h11; rd_by_ev[3] = 8'h22; rd_by_ev[4] = 8'h33;
        run_txn(7'h50, 1'b1, 3, -1, 1'b0, 1'b0, "rd3");

        rand_cfg(1);
        ack_by_ev[1] = 1'b0;
        run_txn(7'h50, 1'b0, 2, -1, 1'b0, 1'b0, "addr_nack");

        rand_cfg(1);
        run_txn(7'h2B, 1'b1, 0, -1, 1'b1, 1'b0, "probe");

        rand_cfg(1);
        run_txn(7'h50, 1'b0, 2, 0, 1'b0, 1'b0, "hang_start");

        rand_cfg(1);
        run_txn(7'h50, 1'b1, 3, -1, 1'b0, 1'b1, "rd_abort");
        rand_cfg(1);
        run_txn(7'h33, 1'b0, 3, -1, 1'b0, 1'b0, "after_abort");

        for (int t = 0; t < 40; t++) begin
            a    = 7'($urandom);
            rnw  = 1'($urandom);
            len  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            hang = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len + 3)) : -1;
            rand_cfg(1'b0);
            run_txn(a, rnw, len, hang, $urandom_range(0, 3) == 0, 1'b0, $sformatf("rnd%0d", t));
        end

        check_val("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
